// File: rtl/win_banner_overlay_pkg.sv
// ============================================================================
// Module : banner_pkg
// Brief  : Shared types and constants for the win-banner overlay stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package banner_pkg;

    localparam int             ADDR_W  = 19;
    localparam int             RGB_W   = 24;
    localparam logic [23:0]    KEY_RGB = 24'hFF0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } banner_state_t;

endpackage

`default_nettype wire

// File: rtl/win_banner_overlay_addr_gen.sv
// ============================================================================
// Module : banner_addr_gen
// Brief  : Combinational banner-box test and frame-RAM address from DrawX/DrawY.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module banner_addr_gen #(
    parameter int X0 = 192,
    parameter int Y0 = 144,
    parameter int W  = 256,
    parameter int H  = 192
) (
    input  logic [9:0]                    i_draw_x,
    input  logic [9:0]                    i_draw_y,
    output logic                          o_in_box,
    output logic [banner_pkg::ADDR_W-1:0] o_addr
);
    import banner_pkg::*;

    localparam int c_LOG2_W = $clog2(W);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;

    assign w_x  = {1'b0, i_draw_x};
    assign w_y  = {1'b0, i_draw_y};
    assign w_dx = i_draw_x - 10'(X0);
    assign w_dy = i_draw_y - 10'(Y0);

    assign o_in_box = (w_x >= 11'(X0)) && (w_x < 11'(X0 + W)) &&
                      (w_y >= 11'(Y0)) && (w_y < 11'(Y0 + H));

    // Forcing 0 outside the box keeps the address inside the W*H RAM.
    assign o_addr = o_in_box ? ((ADDR_W'(w_dy) << c_LOG2_W) + ADDR_W'(w_dx)) : '0;

endmodule

`default_nettype wire

// File: rtl/win_banner_overlay.sv
// ============================================================================
// Module : win_banner_overlay
// Brief  : Game-over win-banner sequencer and 3-stage pixel overlay pipeline.
//          Optional blink in SHOW enabled by defining BANNER_BLINK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module win_banner_overlay #(
    parameter int                          X0          = 192,
    parameter int                          Y0          = 144,
    parameter int                          W           = 256,
    parameter int                          H           = 192,
    parameter int                          HOLD_FRAMES = 180,
    parameter logic [banner_pkg::RGB_W-1:0] KEY_RGB    = banner_pkg::KEY_RGB
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          frame_start,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank_n,
    input  logic [banner_pkg::RGB_W-1:0]  bg_rgb,
    input  logic                          game_over,
    input  logic                          winner,
    input  logic                          restart,
    input  logic [banner_pkg::RGB_W-1:0]  ram_data,
    output logic [banner_pkg::ADDR_W-1:0] read_address,
    output logic                          sprite_sel,
    output logic [banner_pkg::RGB_W-1:0]  rgb_out,
    output logic                          banner_active,
    output logic                          done
);
    import banner_pkg::*;

    localparam int               CNT_W  = (HOLD_FRAMES == 0) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [CNT_W-1:0] c_HOLD = CNT_W'(HOLD_FRAMES);

    banner_state_t     r_state;
    banner_state_t     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_show_entry;
    logic              w_active_nxt;
    logic              w_done_nxt;
    logic              w_sel_nxt;
    logic              r_active;
    logic              r_done;
    logic              r_sel;
    logic              w_vis;

    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r1_addr;
    logic              r1_in_box;
    logic [RGB_W-1:0]  r1_bg;
    logic              r1_blank;
    logic              r1_vis;
    logic              r2_in_box;
    logic [RGB_W-1:0]  r2_bg;
    logic              r2_blank;
    logic              r2_vis;
    logic [RGB_W-1:0]  r3_rgb;

    assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_show_entry = (r_state == ARM) && (w_state_nxt == SHOW);

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // restart overrides every other event in every state.
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (game_over)   w_state_nxt = ARM;
                ARM:     if (frame_start) w_state_nxt = SHOW;
                SHOW:    if (frame_start && (HOLD_FRAMES != 0) && (w_cnt_inc == c_HOLD))
                             w_state_nxt = DONE;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_active_nxt = (w_state_nxt == SHOW);
        w_done_nxt   = (w_state_nxt == DONE);
        w_sel_nxt    = r_sel;
        if ((r_state == IDLE) && game_over && !restart) w_sel_nxt = winner;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_sel    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_active <= w_active_nxt;
            r_done   <= w_done_nxt;
            r_sel    <= w_sel_nxt;
            if (w_show_entry)
                r_cnt <= '0;
            else if ((r_state == SHOW) && frame_start && !restart)
                r_cnt <= w_cnt_inc;
        end
    end

`ifdef BANNER_BLINK_EN
    logic [4:0] r_blink;

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            r_blink <= '0;
        else if (w_show_entry)
            r_blink <= '0;
        else if ((r_state == SHOW) && frame_start)
            r_blink <= r_blink + 5'd1;
    end

    assign w_vis = (r_state == DONE) || ((r_state == SHOW) && !r_blink[4]);
`else
    assign w_vis = (r_state == SHOW) || (r_state == DONE);
`endif

    banner_addr_gen #(
        .X0 (X0),
        .Y0 (Y0),
        .W  (W),
        .H  (H)
    ) u_addr_gen (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .o_in_box (w_in_box),
        .o_addr   (w_addr)
    );

    // Visibility travels with the pixel so a state change never splits one.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r1_addr   <= '0;
            r1_in_box <= 1'b0;
            r1_bg     <= '0;
            r1_blank  <= 1'b0;
            r1_vis    <= 1'b0;
            r2_in_box <= 1'b0;
            r2_bg     <= '0;
            r2_blank  <= 1'b0;
            r2_vis    <= 1'b0;
            r3_rgb    <= '0;
        end else begin
            r1_addr   <= w_addr;
            r1_in_box <= w_in_box;
            r1_bg     <= bg_rgb;
            r1_blank  <= blank_n;
            r1_vis    <= w_vis;
            r2_in_box <= r1_in_box;
            r2_bg     <= r1_bg;
            r2_blank  <= r1_blank;
            r2_vis    <= r1_vis;
            if (!r2_blank)
                r3_rgb <= '0;
            else if (r2_vis && r2_in_box && (ram_data != KEY_RGB))
                r3_rgb <= ram_data;
            else
                r3_rgb <= r2_bg;
        end
    end

    assign read_address  = r1_addr;
    assign rgb_out       = r3_rgb;
    assign banner_active = r_active;
    assign done          = r_done;
    assign sprite_sel    = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_win_banner_overlay.sv
// ============================================================================
// Module : tb_win_banner_overlay
// Brief  : Scoreboard bench for win_banner_overlay with a 1-cycle RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_win_banner_overlay;

`ifdef BANNER_BLINK_EN
    localparam int TB_HOLD = 0;
`else
    localparam int TB_HOLD = 3;
`endif

    localparam int K_RGB = 0;
    localparam int K_ADR = 1;
    localparam int K_ACT = 2;
    localparam int K_DON = 3;
    localparam int K_SEL = 4;

    localparam int c_WATCHDOG = 5000;

    logic        clk;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank_n;
    logic [23:0] bg_rgb;
    logic        game_over;
    logic        winner;
    logic        restart;
    logic [23:0] ram_data;
    logic [18:0] read_address;
    logic        sprite_sel;
    logic [23:0] rgb_out;
    logic        banner_active;
    logic        done;

    typedef struct {
        int          kind;
        int          due;
        logic [23:0] val;
    } exp_t;

    exp_t  q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fail   = 0;
    string nm[5]    = '{"rgb_out", "read_address", "banner_active", "done", "sprite_sel"};

    win_banner_overlay #(
        .X0          (192),
        .Y0          (144),
        .W           (256),
        .H           (192),
        .HOLD_FRAMES (TB_HOLD),
        .KEY_RGB     (24'hFF0000)
    ) dut (
        .Clk           (clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .blank_n       (blank_n),
        .bg_rgb        (bg_rgb),
        .game_over     (game_over),
        .winner        (winner),
        .restart       (restart),
        .ram_data      (ram_data),
        .read_address  (read_address),
        .sprite_sel    (sprite_sel),
        .rgb_out       (rgb_out),
        .banner_active (banner_active),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM model: two marked locations, elsewhere the address itself.
    function automatic logic [23:0] ram_lookup(input logic [18:0] a);
        if (a == 19'd1544) return 24'h9FF5FF;
        if (a == 19'd1545) return 24'hFF0000;
        return {5'd0, a};
    endfunction

    initial ram_data = 24'h0;
    always @(posedge clk) ram_data <= ram_lookup(read_address);

    function automatic logic [23:0] actual(input int k);
        case (k)
            K_RGB:   return rgb_out;
            K_ADR:   return {5'd0, read_address};
            K_ACT:   return {23'd0, banner_active};
            K_DON:   return {23'd0, done};
            default: return {23'd0, sprite_sel};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                n_checks++;
                if (q[i].due != cyc || actual(q[i].kind) !== q[i].val) begin
                    n_fail++;
                    $display("FAIL %s at cycle %0d (due %0d): actual %h, expected %h",
                             nm[q[i].kind], cyc, q[i].due, actual(q[i].kind), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic chk_eq(input string s, input logic [23:0] a, input logic [23:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual %h, expected %h", s, cyc, a, e);
        end
    endtask

    task automatic chk_idle();
        chk_eq("rgb_out",       rgb_out,                 24'h0);
        chk_eq("read_address",  {5'd0, read_address},    24'h0);
        chk_eq("banner_active", {23'd0, banner_active},  24'h0);
        chk_eq("done",          {23'd0, done},           24'h0);
        chk_eq("sprite_sel",    {23'd0, sprite_sel},     24'h0);
    endtask

    task automatic push(input int k, input int off, input logic [23:0] v);
        q.push_back('{k, cyc + off, v});
    endtask

    task automatic pix(input int x, input int y, input logic bl,
                       input logic [23:0] bg, input logic rn);
        @(negedge clk);
        Reset_n     = rn;
        game_over   = 1'b0;
        frame_start = 1'b0;
        restart     = 1'b0;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        blank_n     = bl;
        bg_rgb      = bg;
    endtask

    task automatic pchk(input int x, input int y, input logic bl, input logic [23:0] bg,
                        input logic [23:0] exp_addr, input logic [23:0] exp_rgb);
        pix(x, y, bl, bg, 1'b1);
        push(K_ADR, 1, exp_addr);
        push(K_RGB, 3, exp_rgb);
    endtask

    task automatic ctl(input logic go, input logic win, input logic fs, input logic rs);
        @(negedge clk);
        Reset_n     = 1'b1;
        game_over   = go;
        winner      = win;
        frame_start = fs;
        restart     = rs;
        DrawX       = '0;
        DrawY       = '0;
        blank_n     = 1'b0;
        bg_rgb      = '0;
    endtask

    task automatic fsm_chk(input logic act, input logic dn, input logic sel);
        push(K_ACT, 1, {23'd0, act});
        push(K_DON, 1, {23'd0, dn});
        push(K_SEL, 1, {23'd0, sel});
    endtask

    initial begin
        repeat (c_WATCHDOG) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog expired after %0d cycles", c_WATCHDOG);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0; blank_n = 1'b0;
        bg_rgb = '0; game_over = 1'b0; winner = 1'b0; restart = 1'b0;

        // Reset holds everything at zero even with an in-box pixel applied.
        pix(200, 150, 1'b1, 24'h123456, 1'b0);
        pix(200, 150, 1'b1, 24'h123456, 1'b0);
        chk_idle();
        push(K_ADR, 1, 24'h0);
        push(K_RGB, 1, 24'h0);
        fsm_chk(1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);

        // IDLE -> ARM with Player2, ARM -> SHOW on frame boundary.
        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        fsm_chk(1'b0, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b1, 1'b0, 1'b1);

        // Pixel datapath in SHOW.
        pchk(192, 144, 1'b1, 24'h555555, 24'd0,     24'h000000);
        pchk(447, 335, 1'b1, 24'h555555, 24'd49151, 24'h00BFFF);
        pchk(447, 144, 1'b1, 24'h555555, 24'd255,   24'h0000FF);
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544,  24'h9FF5FF);
        pchk(201, 150, 1'b1, 24'h123456, 24'd1545,  24'h123456);
        pchk(100, 150, 1'b1, 24'hABCDEF, 24'd0,     24'hABCDEF);
        pchk(200, 150, 1'b0, 24'h111111, 24'd1544,  24'h000000);
        pchk(192, 336, 1'b1, 24'h222222, 24'd0,     24'h222222);
        pchk(448, 144, 1'b1, 24'h333333, 24'd0,     24'h333333);
        pchk(191, 144, 1'b1, 24'h444444, 24'd0,     24'h444444);

        // game_over outside IDLE is ignored.
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        fsm_chk(1'b1, 1'b0, 1'b1);

`ifndef BANNER_BLINK_EN
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b1, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b1, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b0, 1'b1, 1'b1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544, 24'h9FF5FF);
`endif

        // restart beats a coincident game_over and frame_start.
        ctl(1'b1, 1'b0, 1'b1, 1'b1);
        fsm_chk(1'b0, 1'b0, 1'b1);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b0, 1'b0, 1'b1);
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544, 24'h123456);

        ctl(1'b1, 1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b1, 1'b0, 1'b1);

`ifdef BANNER_BLINK_EN
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544, 24'h9FF5FF);
        for (int i = 0; i < 15; i++) ctl(1'b0, 1'b0, 1'b1, 1'b0);
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544, 24'h9FF5FF);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        pchk(200, 150, 1'b1, 24'h123456, 24'd1544, 24'h123456);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset in the middle of SHOW.
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        pix(200, 150, 1'b1, 24'h123456, 1'b0);
        push(K_ADR, 1, 24'h0);
        push(K_RGB, 1, 24'h0);
        fsm_chk(1'b0, 1'b0, 1'b0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        fsm_chk(1'b0, 1'b0, 1'b0);

        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk_idle();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %0d expectation(s) never evaluated", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
